// File: rtl/fruit_slot_scheduler.sv
// Four-slot fruit spawner for the game: a per-slot IDLE/HANGING/FALLING FSM,
// an LFSR for fruit types, and a frame counter that paces spawn attempts.
module fruit_slot_scheduler #(
  parameter int unsigned SPAWN_PERIOD = 120,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       enable,
  input  logic [3:0] collision,
  input  logic [3:0] floor_hit,
  output logic [7:0] fruit1_type,
  output logic [7:0] fruit2_type,
  output logic [7:0] fruit3_type,
  output logic [7:0] fruit4_type,
  output logic [3:0] slot_active,
  output logic [3:0] slot_falling,
  output logic       score_pulse,
  output logic [7:0] score_value
);

  localparam logic [7:0] LAST_FRAME = 8'(SPAWN_PERIOD - 1);

  // bit 0 = slot occupied, bit 1 = falling; the outputs decode straight from the flops
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_HANGING = 2'b01;
  localparam logic [1:0] ST_FALLING = 2'b11;

  logic [7:0] r_lfsr;
  logic [7:0] r_frame_cnt;
  logic [1:0] r_state [4];
  logic [7:0] r_type  [4];
  logic       r_score_pulse;
  logic [7:0] r_score_value;

  logic       w_lfsr_fb;
  logic       w_frame_tick;
  logic       w_wrap;
  logic [3:0] w_idle;
  logic [3:0] w_spawn_sel;
  logic [3:0] w_collect;
  logic [3:0] w_drop;
  logic [7:0] w_spawn_type;
  logic [7:0] w_score_sum;
  logic [1:0] w_state_nxt [4];
  logic [7:0] w_type_nxt  [4];

  assign w_lfsr_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_frame_tick = startOfFrame & enable;
  assign w_wrap       = w_frame_tick && (r_frame_cnt == LAST_FRAME);
  assign w_spawn_type = {6'd0, r_lfsr[1:0]} + 8'd1;

  always_comb begin
    w_idle      = '0;
    w_collect   = '0;
    w_drop      = '0;
    w_score_sum = '0;
    for (int i = 0; i < 4; i++) begin
      w_idle[i]    = (r_state[i] == ST_IDLE);
      w_collect[i] = collision[i] && (r_state[i] == ST_HANGING);
      w_drop[i]    = floor_hit[i] && (r_state[i] == ST_FALLING);
      if (w_collect[i]) w_score_sum = w_score_sum + 8'(r_type[i] * 8'd10);
    end
    // lowest set bit of the idle mask; a slot freed this cycle is still FALLING here
    w_spawn_sel = w_wrap ? (w_idle & (~w_idle + 4'd1)) : 4'd0;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_state_nxt[i] = r_state[i];
      w_type_nxt[i]  = r_type[i];
      if (w_spawn_sel[i]) begin
        w_state_nxt[i] = ST_HANGING;
        w_type_nxt[i]  = w_spawn_type;
      end else if (w_collect[i]) begin
        w_state_nxt[i] = ST_FALLING;
      end else if (w_drop[i]) begin
        w_state_nxt[i] = ST_IDLE;
        w_type_nxt[i]  = 8'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_lfsr        <= LFSR_SEED;
      r_frame_cnt   <= 8'd0;
      r_score_pulse <= 1'b0;
      r_score_value <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        r_state[i] <= ST_IDLE;
        r_type[i]  <= 8'd0;
      end
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
      if (w_frame_tick) r_frame_cnt <= w_wrap ? 8'd0 : r_frame_cnt + 8'd1;
      r_score_pulse <= |w_collect;
      r_score_value <= (|w_collect) ? w_score_sum : 8'd0;
      for (int i = 0; i < 4; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_type[i]  <= w_type_nxt[i];
      end
    end
  end

  assign fruit1_type  = r_type[0];
  assign fruit2_type  = r_type[1];
  assign fruit3_type  = r_type[2];
  assign fruit4_type  = r_type[3];
  assign slot_active  = {r_state[3][0], r_state[2][0], r_state[1][0], r_state[0][0]};
  assign slot_falling = {r_state[3][1], r_state[2][1], r_state[1][1], r_state[0][1]};
  assign score_pulse  = r_score_pulse;
  assign score_value  = r_score_value;

endmodule

// File: tb/tb_fruit_slot_scheduler.sv
// Bench for fruit_slot_scheduler with SPAWN_PERIOD=4: directed scenarios plus random
// traffic, all compared against a frame/slot reference model held in the bench.
module tb_fruit_slot_scheduler;

  localparam int SP = 4;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] collision = 4'd0;
  logic [3:0] floor_hit = 4'd0;
  logic [7:0] fruit1_type, fruit2_type, fruit3_type, fruit4_type;
  logic [3:0] slot_active, slot_falling;
  logic       score_pulse;
  logic [7:0] score_value;

  fruit_slot_scheduler #(.SPAWN_PERIOD(SP), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
    .collision(collision), .floor_hit(floor_hit),
    .fruit1_type(fruit1_type), .fruit2_type(fruit2_type),
    .fruit3_type(fruit3_type), .fruit4_type(fruit4_type),
    .slot_active(slot_active), .slot_falling(slot_falling),
    .score_pulse(score_pulse), .score_value(score_value)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model: slot condition 0 empty, 1 hanging, 2 falling
  int m_lfsr, m_cnt, m_score, m_pulse;
  int m_st [4];
  int m_ty [4];

  function automatic void model_reset();
    m_lfsr = 'hA5; m_cnt = 0; m_score = 0; m_pulse = 0;
    for (int i = 0; i < 4; i++) begin m_st[i] = 0; m_ty[i] = 0; end
  endfunction

  function automatic void model_clock(input bit sof, input bit en,
                                      input logic [3:0] col, input logic [3:0] fh);
    int lf, target, sum, fb;
    bit attempt;
    lf = m_lfsr; target = -1; sum = 0; attempt = 0;
    if (sof && en) begin
      attempt = (m_cnt == SP - 1);
      m_cnt = attempt ? 0 : m_cnt + 1;
    end
    if (attempt)
      for (int i = 0; i < 4; i++) if (target < 0 && m_st[i] == 0) target = i;
    for (int i = 0; i < 4; i++) begin
      if (m_st[i] == 1 && col[i]) begin
        m_st[i] = 2; sum += 10 * m_ty[i];
      end else if (m_st[i] == 2 && fh[i]) begin
        m_st[i] = 0; m_ty[i] = 0;
      end else if (i == target) begin
        m_st[i] = 1; m_ty[i] = (lf % 4) + 1;
      end
    end
    m_pulse = (sum != 0);
    m_score = sum;
    fb = ((lf >> 7) ^ (lf >> 5) ^ (lf >> 4) ^ (lf >> 3)) & 1;
    m_lfsr = ((lf << 1) & 'hFF) | fb;
  endfunction

  function automatic logic [48:0] dut_vec();
    return {fruit4_type, fruit3_type, fruit2_type, fruit1_type,
            slot_active, slot_falling, score_pulse, score_value};
  endfunction

  function automatic logic [48:0] mdl_vec();
    logic [3:0] a, f;
    for (int i = 0; i < 4; i++) begin a[i] = (m_st[i] != 0); f[i] = (m_st[i] == 2); end
    return {8'(m_ty[3]), 8'(m_ty[2]), 8'(m_ty[1]), 8'(m_ty[0]), a, f, 1'(m_pulse), 8'(m_score)};
  endfunction

  // driver tasks
  task automatic tick(input bit sof, input bit en, input logic [3:0] col, input logic [3:0] fh);
    startOfFrame = sof; enable = en; collision = col; floor_hit = fh;
    @(posedge clk);
    model_clock(sof, en, col, fh);
    #1;
    startOfFrame = 1'b0; collision = 4'd0; floor_hit = 4'd0;
  endtask

  task automatic frame(input bit en);
    int gap;
    tick(1'b1, en, 4'd0, 4'd0);
    gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) tick(1'b0, en, 4'd0, 4'd0);
  endtask

  task automatic do_reset();
    resetN = 1'b0; startOfFrame = 1'b0; collision = 4'd0; floor_hit = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    model_reset();
  endtask

  // reach the wrap frame, then idle until the LFSR will yield the wanted type
  task automatic spawn_with_type(input int t);
    int guard;
    guard = 0;
    while (m_cnt != SP - 1) frame(1'b1);
    while ((m_lfsr % 4) != t - 1 && guard < 64) begin tick(1'b0, 1'b1, 4'd0, 4'd0); guard++; end
    if ((m_lfsr % 4) != t - 1) begin
      n_cmp++; n_fail++;
      $display("FAIL align_type: lfsr %0h never gave type %0d", m_lfsr, t);
    end
    tick(1'b1, 1'b1, 4'd0, 4'd0);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (dut_vec() !== 49'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", dut_vec()); end
    tick(1'b0, 1'b0, 4'hF, 4'hF);
    n_cmp++;
    if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL reset_idle_inputs: got %h expected %h", dut_vec(), mdl_vec()); end
  endtask

  task automatic test_basic_spawn();
    do_reset();
    for (int i = 0; i < SP; i++) begin
      frame(1'b1);
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL basic_frame%0d: got %h expected %h", i, dut_vec(), mdl_vec()); end
    end
    n_cmp++;
    if (slot_active !== 4'b0001 || fruit1_type < 8'd1 || fruit1_type > 8'd4) begin
      n_fail++; $display("FAIL basic_spawn: active %b type %0d, expected 0001 and type 1..4", slot_active, fruit1_type);
    end
  endtask

  task automatic test_full_slots();
    do_reset();
    for (int i = 0; i < 5 * SP; i++) begin
      frame(1'b1);
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL full_frame%0d: got %h expected %h", i, dut_vec(), mdl_vec()); end
      if (i == 4 * SP - 1 || i == 5 * SP - 1) begin
        n_cmp++;
        if (slot_active !== 4'b1111) begin n_fail++; $display("FAIL full_active%0d: got %b expected 1111", i, slot_active); end
      end
    end
  endtask

  task automatic test_collect_drop();
    do_reset();
    spawn_with_type(3);
    n_cmp++;
    if (fruit1_type !== 8'd3 || slot_active !== 4'b0001) begin
      n_fail++; $display("FAIL collect_setup: type %0d active %b expected 3 0001", fruit1_type, slot_active);
    end
    tick(1'b0, 1'b1, 4'b0001, 4'd0);
    n_cmp++;
    if (slot_falling !== 4'b0001 || score_pulse !== 1'b1 || score_value !== 8'd30) begin
      n_fail++; $display("FAIL collect_score: falling %b pulse %b value %0d expected 0001 1 30", slot_falling, score_pulse, score_value);
    end
    tick(1'b0, 1'b1, 4'b0001, 4'd0);
    n_cmp++;
    if (score_pulse !== 1'b0 || score_value !== 8'd0 || slot_falling !== 4'b0001) begin
      n_fail++; $display("FAIL collect_while_falling: pulse %b value %0d falling %b expected 0 0 0001", score_pulse, score_value, slot_falling);
    end
    tick(1'b0, 1'b1, 4'd0, 4'b0001);
    n_cmp++;
    if (fruit1_type !== 8'd0 || slot_active[0] !== 1'b0 || dut_vec() !== mdl_vec()) begin
      n_fail++; $display("FAIL drop: got %h expected %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    spawn_with_type(2);
    spawn_with_type(4);
    tick(1'b0, 1'b1, 4'd0, 4'b0011);
    n_cmp++;
    if (slot_active !== 4'b0011 || slot_falling !== 4'b0000 || fruit1_type !== 8'd2 || fruit2_type !== 8'd4) begin
      n_fail++; $display("FAIL floor_on_hanging: active %b falling %b types %0d %0d expected 0011 0000 2 4", slot_active, slot_falling, fruit1_type, fruit2_type);
    end
    tick(1'b0, 1'b1, 4'b0011, 4'd0);
    n_cmp++;
    if (score_pulse !== 1'b1 || score_value !== 8'd60 || slot_falling !== 4'b0011) begin
      n_fail++; $display("FAIL double_collect: pulse %b value %0d falling %b expected 1 60 0011", score_pulse, score_value, slot_falling);
    end
    tick(1'b0, 1'b1, 4'd0, 4'd0);
    n_cmp++;
    if (score_pulse !== 1'b0 || score_value !== 8'd0) begin
      n_fail++; $display("FAIL double_collect_single: pulse %b value %0d expected 0 0", score_pulse, score_value);
    end
  endtask

  task automatic test_back_to_back_race();
    do_reset();
    for (int i = 0; i < 4 * SP; i++) frame(1'b1);
    tick(1'b0, 1'b1, 4'b0001, 4'd0);
    while (m_cnt != SP - 1) frame(1'b1);
    tick(1'b1, 1'b1, 4'd0, 4'b0001);
    n_cmp++;
    if (slot_active !== 4'b1110 || fruit1_type !== 8'd0 || dut_vec() !== mdl_vec()) begin
      n_fail++; $display("FAIL race_no_spawn: got %h expected %h", dut_vec(), mdl_vec());
    end
    for (int i = 0; i < SP; i++) frame(1'b1);
    n_cmp++;
    if (slot_active !== 4'b1111 || dut_vec() !== mdl_vec()) begin
      n_fail++; $display("FAIL race_refill: got %h expected %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_enable_reset();
    do_reset();
    frame(1'b1); frame(1'b1);
    for (int i = 0; i < 10; i++) frame(1'b0);
    n_cmp++;
    if (slot_active !== 4'b0000 || dut_vec() !== mdl_vec()) begin
      n_fail++; $display("FAIL enable_low: got %h expected %h", dut_vec(), mdl_vec());
    end
    frame(1'b1);
    n_cmp++;
    if (slot_active !== 4'b0000) begin n_fail++; $display("FAIL counter_held_a: active %b expected 0000", slot_active); end
    frame(1'b1);
    n_cmp++;
    if (slot_active !== 4'b0001) begin n_fail++; $display("FAIL counter_held_b: active %b expected 0001", slot_active); end
    for (int i = 0; i < 2 * SP; i++) frame(1'b1);
    tick(1'b0, 1'b0, 4'b0010, 4'd0);
    n_cmp++;
    if (slot_active !== 4'b0111 || score_pulse !== 1'b1 || dut_vec() !== mdl_vec()) begin
      n_fail++; $display("FAIL collide_disabled: got %h expected %h", dut_vec(), mdl_vec());
    end
    resetN = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec() !== 49'd0) begin n_fail++; $display("FAIL reset_async: got %h expected 0", dut_vec()); end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    for (int i = 0; i < SP; i++) begin
      frame(1'b1);
      n_cmp++;
      if (slot_active !== ((i == SP - 1) ? 4'b0001 : 4'b0000) || dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL post_reset_frame%0d: got %h expected %h", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] col, fh;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      col = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      fh  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      tick($urandom_range(0, 2) == 0, $urandom_range(0, 7) != 0, col, fh);
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL random_cycle%0d: got %h expected %h", i, dut_vec(), mdl_vec()); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_spawn();
    test_full_slots();
    test_collect_drop();
    test_simultaneous();
    test_back_to_back_race();
    test_enable_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
